// File: rtl/uart_tx_shift_register.sv
// UART transmit serializer: start bit, 5..MAX_DATA_BITS data bits (LSB- or
// MSB-first), optional parity, 1 or 2 stop bits. Each bit lasts CLKS_PER_BIT
// clocks. Parity is built only when UART_TX_PARITY_EN is defined.
module uart_tx_shift_register #(
    parameter int unsigned MAX_DATA_BITS = 9,
    parameter int unsigned CLKS_PER_BIT  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [MAX_DATA_BITS-1:0] tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    input  logic [3:0]               data_bits,
    input  logic                     lsb_first,
    input  logic                     stop_bits_2,
    input  logic                     parity_en,
    input  logic                     parity_odd,
    output logic                     tx_serial,
    output logic                     tx_busy,
    output logic [3:0]               bit_count,
    output logic                     frame_done
);

    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [3:0]  MIN_BITS = 4'd5;
    localparam logic [3:0]  MAX_BITS = 4'(MAX_DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                   state;
    logic [CNT_W-1:0]         clk_cnt;
    logic [3:0]               bit_idx;
    logic [3:0]               last_idx;
    logic                     lsb_q;
    logic                     stop2_q;
    logic                     stop_idx;
    logic [MAX_DATA_BITS-1:0] shreg;

    logic [3:0]               n_c;
    logic [MAX_DATA_BITS-1:0] masked_c;
    logic [MAX_DATA_BITS-1:0] aligned_c;
    logic                     head_c;
    logic [MAX_DATA_BITS-1:0] shifted_c;
    logic                     bit_last_c;
    logic                     bit_almost_c;

    // Clamp requested width, drop bits above n-1, left-align for MSB-first
    assign n_c       = (data_bits < MIN_BITS) ? MIN_BITS :
                       (data_bits > MAX_BITS) ? MAX_BITS : data_bits;
    assign masked_c  = tx_data & ({MAX_DATA_BITS{1'b1}} >> (MAX_BITS - n_c));
    assign aligned_c = lsb_first ? masked_c : (masked_c << (MAX_BITS - n_c));

    // Next data bit always comes from one end of the shift register
    assign head_c    = lsb_q ? shreg[0] : shreg[MAX_DATA_BITS-1];
    assign shifted_c = lsb_q ? (shreg >> 1) : (shreg << 1);

    assign bit_last_c   = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign bit_almost_c = (clk_cnt == CNT_W'(CLKS_PER_BIT - 2));

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_bit_q;
`else
    logic unused_parity;
    assign unused_parity = parity_en ^ parity_odd;
`endif

    // Frame sequencer with registered line and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            last_idx   <= '0;
            lsb_q      <= 1'b1;
            stop2_q    <= 1'b0;
            stop_idx   <= 1'b0;
            shreg      <= '0;
            tx_serial  <= 1'b1;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            bit_count  <= '0;
            frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            clk_cnt    <= bit_last_c ? '0 : clk_cnt + CNT_W'(1);
            case (state)
                S_IDLE: begin
                    clk_cnt   <= '0;
                    tx_serial <= 1'b1;
                    tx_ready  <= 1'b1;
                    tx_busy   <= 1'b0;
                    bit_count <= '0;
                    if (tx_valid && tx_ready) begin
                        shreg     <= aligned_c;
                        last_idx  <= n_c - 4'd1;
                        lsb_q     <= lsb_first;
                        stop2_q   <= stop_bits_2;
`ifdef UART_TX_PARITY_EN
                        par_en_q  <= parity_en;
                        par_bit_q <= (^masked_c) ^ parity_odd;
`endif
                        state     <= S_START;
                        tx_serial <= 1'b0;
                        tx_ready  <= 1'b0;
                        tx_busy   <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_last_c) begin
                        state     <= S_DATA;
                        tx_serial <= head_c;
                        shreg     <= shifted_c;
                        bit_idx   <= '0;
                        bit_count <= '0;
                    end
                end
                S_DATA: begin
                    if (bit_last_c) begin
                        if (bit_idx == last_idx) begin
                            bit_count <= '0;
                            stop_idx  <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            if (par_en_q) begin
                                state     <= S_PARITY;
                                tx_serial <= par_bit_q;
                            end else begin
                                state     <= S_STOP;
                                tx_serial <= 1'b1;
                            end
`else
                            state     <= S_STOP;
                            tx_serial <= 1'b1;
`endif
                        end else begin
                            bit_idx   <= bit_idx + 4'd1;
                            bit_count <= bit_idx + 4'd1;
                            tx_serial <= head_c;
                            shreg     <= shifted_c;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_last_c) begin
                        state     <= S_STOP;
                        tx_serial <= 1'b1;
                        stop_idx  <= 1'b0;
                    end
                end
`endif
                S_STOP: begin
                    if (stop_idx == stop2_q) begin
                        if (bit_almost_c) begin
                            frame_done <= 1'b1;
                        end
                        if (bit_last_c) begin
                            state    <= S_IDLE;
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                        end
                    end else if (bit_last_c) begin
                        stop_idx <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    tx_serial <= 1'b1;
                    tx_ready  <= 1'b1;
                    tx_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
